mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the MiniSys1A execute stage.
//  Accepts MULT/MULTU/DIV/DIVU from EX, sequences a shift-add multiplier or a
//  restoring divider over W cycles, and writes HI/LO.
//  Raises stall to the pipeline register enables for the whole operation.
// PARAMETERS
//  W      32   operand width; counter width is clog2(W)+1
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous reset, active-high
//  start     in   1   request; sampled only in IDLE
//  op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a         in   W   multiplicand / dividend, sampled with start
//  b         in   W   multiplier / divisor, sampled with start
//  cancel    in   1   flush from pipeline; aborts the operation in flight
//  busy      out  1   state != IDLE
//  stall     out  1   busy | (start & ~cancel); freezes the upstream pipeline regs
//  done      out  1   one-cycle pulse when hi/lo update
//  hi        out  W   MULT: product[2W-1:W]; DIV: remainder
//  lo        out  W   MULT: product[W-1:0];  DIV: quotient
//  div_zero  out  1   set with done when a DIV/DIVU had b==0; held until next done
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; busy, done, div_zero = 0; hi, lo = 0;
//   counter and working regs = 0. Reset mid-operation aborts it with no done.
//  FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start & ~cancel at edge T -> latch op, |a|, |b|, operand signs
//    (signed ops only) -> CALC. Counter = 0.
//   CALC: one iteration per cycle; counter++; after W iterations (T+1..T+W) -> FIX.
//   FIX: apply sign correction -> DONE.
//   DONE: hi/lo registered, done=1 for exactly this cycle -> IDLE.
//  Latency: start at edge T -> done high in cycle T+W+2; next start accepted at T+W+3.
//  start while busy (including DONE) is ignored; no queueing.
//  cancel: from any non-IDLE state -> IDLE at the next edge.
//   No done is produced; hi, lo and div_zero are unchanged.
//   cancel & start together in IDLE: the start is dropped.
//  hi/lo/div_zero hold between done pulses.
//  MULT: 2W-bit two's-complement product of signed a*b; MULTU: unsigned.
//   Signed product = magnitude product, negated when the signs differ.
//  DIV/DIVU: quotient truncates toward zero; remainder takes the dividend's sign
//   (signed); unsigned is plain restoring division.
//  b==0 on DIV/DIVU: full latency still applies.
//   Result: lo = {W{1}}, hi = a (raw input); div_zero = 1.
//   MULT ops clear div_zero at done.
//  DIV overflow, a = 0x80000000 / b = -1: lo = 0x80000000, hi = 0 (wraps, no flag).
//  Working regs: 2W+1-bit accumulator/remainder; W-bit shift reg; all arithmetic mod 2^W.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at T+34; hi=0xFFFFFFFE lo=0x00000001.
//  2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB;
//    DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3 DIVU a=100 b=0 -> done at T+34; lo=0xFFFFFFFF hi=100 div_zero=1.
//    Following MULTU 2*3 -> div_zero=0, lo=6.
//  4 DIVU 50/7 started, cancel at T+10 -> busy=0 at T+11, no done, hi/lo keep old values.
//    Restart -> lo=7 hi=1.
//  5 start pulsed at T+5 during an op -> ignored; stall=1 for T..T+34.
//    Back-to-back start in cycle T+35 accepted.
//  6 rst at T+20 mid-DIV -> all outputs 0 next cycle.
//    DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    // EX stage side
    modport master (
        output start, op, a, b, cancel,
        input  busy, stall, done, hi, lo, div_zero
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: shift-add multiplier and restoring
// divider working on operand magnitudes, with sign correction applied in FIX.
module mdu_seq #(
    parameter int W = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]    r_op;
    logic          r_sa;
    logic          r_sb;
    logic [W-1:0]  r_ma;
    logic [W-1:0]  r_mb;
    logic [CW-1:0] r_cnt;
    logic [2*W:0]  r_acc;
    logic [W-1:0]  r_sr;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic          r_dz;

    logic          w_accept;
    logic          w_in_sa;
    logic          w_in_sb;
    logic [W-1:0]  w_in_ma;
    logic [W-1:0]  w_in_mb;
    logic [W:0]    w_madd;
    logic [W:0]    w_trial;
    logic          w_ge;
    logic [W:0]    w_rem_nx;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]  w_quo_fix;
    logic [W-1:0]  w_rem_fix;
    logic [W-1:0]  w_a_raw;
    logic [W-1:0]  w_hi_fin;
    logic [W-1:0]  w_lo_fin;
    logic          w_dz_fin;

    assign w_accept = bus.start & ~bus.cancel;

    // Operand signs only matter for the signed ops (op[0] == 0)
    assign w_in_sa = ~bus.op[0] & bus.a[W-1];
    assign w_in_sb = ~bus.op[0] & bus.b[W-1];
    assign w_in_ma = w_in_sa ? -bus.a : bus.a;
    assign w_in_mb = w_in_sb ? -bus.b : bus.b;

    // Multiply step: conditional add of the multiplicand into the upper half
    assign w_madd = r_acc[2*W:W] + (r_acc[0] ? {1'b0, r_ma} : '0);

    // Divide step: shift in the next dividend bit and trial-subtract
    assign w_trial  = {r_acc[W-1:0], r_sr[W-1]};
    assign w_ge     = w_trial >= {1'b0, r_mb};
    assign w_rem_nx = w_ge ? (w_trial - {1'b0, r_mb}) : w_trial;

    // Sign correction on the magnitude results
    assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
    assign w_quo_fix  = (r_sa ^ r_sb) ? -r_sr : r_sr;
    assign w_rem_fix  = r_sa ? -r_acc[W-1:0] : r_acc[W-1:0];
    // Raw dividend rebuilt from magnitude and sign for the divide-by-zero result
    assign w_a_raw    = r_sa ? -r_ma : r_ma;

    // Final result selection, captured into hi/lo when leaving FIX
    always_comb begin
        w_hi_fin = w_prod_fix[2*W-1:W];
        w_lo_fin = w_prod_fix[W-1:0];
        w_dz_fin = 1'b0;
        if (r_op[1]) begin
            if (r_mb == '0) begin
                w_hi_fin = w_a_raw;
                w_lo_fin = '1;
                w_dz_fin = 1'b1;
            end else begin
                w_hi_fin = w_rem_fix;
                w_lo_fin = w_quo_fix;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; cancel returns any active state to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (bus.cancel) w_next = S_IDLE;
                else if (r_cnt == CW'(W - 1)) w_next = S_FIX;
            end
            S_FIX:  w_next = bus.cancel ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ma  <= '0;
            r_mb  <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_sr  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_sa  <= w_in_sa;
                        r_sb  <= w_in_sb;
                        r_ma  <= w_in_ma;
                        r_mb  <= w_in_mb;
                        r_cnt <= '0;
                        r_acc <= bus.op[1] ? '0 : {{(W+1){1'b0}}, w_in_mb};
                        r_sr  <= bus.op[1] ? w_in_ma : '0;
                    end
                end
                S_CALC: begin
                    if (!bus.cancel) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_op[1]) begin
                            r_acc <= {{W{1'b0}}, w_rem_nx};
                            r_sr  <= {r_sr[W-2:0], w_ge};
                        end else begin
                            r_acc <= {1'b0, w_madd, r_acc[W-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        r_hi <= w_hi_fin;
                        r_lo <= w_lo_fin;
                        r_dz <= w_dz_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.stall    = (r_state != S_IDLE) | w_accept;
    assign bus.done     = (r_state == S_DONE);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.div_zero = r_dz;
endmodule
